// File: rtl/svnet_acc_ram.sv
// ---------------------------------------------------------------------------
// svnet_acc_ram
//
// Partial-sum store for the convolution datapath. It is a single-clock RAM
// with one write port and one read port. Each write either stores its data or
// adds it to the word already there (accumulate). Reads see every write
// presented at least one cycle earlier, through stage-B forwarding. A
// hardware sweep can zero-fill the whole array.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst_n           : asynchronous, active-low reset
//   clear           : start (or restart) a zero-fill sweep of the array
//   busy            : sweep in progress; requests are ignored while high
//   write           : write request
//   write_mode      : 0 = store, 1 = accumulate
//   write_address   : write address (< DEPTH)
//   write_data      : store value or signed addend
//   read            : read request
//   read_address    : read address (< DEPTH)
//   read_data_valid : read_data carries a result this cycle
//   read_data       : read result; holds its value when read_data_valid is low
//
// Pipeline (request presented in cycle N)
//   N+1 stage A : registered request; fetch old word (with forwarding), and
//                 compute the new word
//   N+2 stage B : new word is written into the array at the end of the cycle
//   Reads are registered in N+1 and the result is registered for N+2.
// ---------------------------------------------------------------------------
module svnet_acc_ram #(
    parameter int DEPTH    = 1,
    parameter int WIDTH    = 1,
    parameter bit SATURATE = 1'b0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic             busy,
    input  logic             write,
    input  logic             write_mode,
    input  logic [AW-1:0]    write_address,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read,
    input  logic [AW-1:0]    read_address,
    output logic             read_data_valid,
    output logic [WIDTH-1:0] read_data
);

    // A one-word array still carries a 1-bit address; a second, never
    // addressed word keeps every index width exact.
    localparam int MEM_DEPTH = (DEPTH > 1) ? DEPTH : 2;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    // Signed limits for the saturating accumulate.
    localparam logic [WIDTH-1:0] SMIN      = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SMAX      = ~SMIN;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } sweep_state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic             a_valid;
    logic             a_mode;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_data;

    logic             r_valid;
    logic [AW-1:0]    r_addr;

    logic             b_valid;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_data;

    // ------------------------------------------------------------------
    // Sweep control
    // ------------------------------------------------------------------
    sweep_state_e     state_q;
    sweep_state_e     state_d;
    logic [AW-1:0]    sweep_addr_q;
    logic [AW-1:0]    sweep_addr_d;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic             a_live;
    logic             b_live;
    logic             r_live;
    logic [WIDTH-1:0] a_old;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH:0]   sum;
    logic             overflow;
    logic [WIDTH-1:0] acc_result;
    logic [WIDTH-1:0] a_new;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign busy = (state_q == S_SWEEP);

    // The first busy cycle is the cycle after clear was presented. At that
    // point stage B holds the write from the cycle before clear, stage A the
    // write presented with clear, and the read stage the read presented with
    // clear. Gating all three with busy discards exactly those. Later busy
    // cycles have empty stages, because requests are not accepted while busy.
    assign a_live = a_valid & ~busy;
    assign b_live = b_valid & ~busy;
    assign r_live = r_valid & ~busy;

    // Stage B has not reached the array yet, so its value overrides the
    // array word for a matching stage-A fetch or registered read.
    assign a_old  = (b_live && (b_addr == a_addr)) ? b_data : mem[a_addr];
    assign r_word = (b_live && (b_addr == r_addr)) ? b_data : mem[r_addr];

    // Signed WIDTH+1-bit sum. The two top bits differ exactly when the
    // result does not fit in WIDTH bits.
    assign sum      = {a_old[WIDTH-1], a_old} + {a_data[WIDTH-1], a_data};
    assign overflow = sum[WIDTH] ^ sum[WIDTH-1];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        acc_result = sum[WIDTH-1:0];
        if (SATURATE && overflow) begin
            acc_result = sum[WIDTH] ? SMIN : SMAX;
        end
    end

    assign a_new = a_mode ? acc_result : a_data;

    // Single array write port, shared between the sweep and stage B. They
    // never collide, because stage B is gated off while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = b_addr;
        mem_wdata = b_data;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr_q;
            mem_wdata = '0;
        end else if (b_live) begin
            mem_we    = 1'b1;
        end
    end

    // NOTE: the array has no reset. A memory with a reset cannot map onto
    // RAM, and the clear sweep gives a defined state when one is needed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // flop samples values from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sweep_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
        end
    end

    // Sweep FSM: next state. Clear always wins and restarts at address 0,
    // so a clear during a sweep extends it.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        if (clear) begin
            state_d      = S_SWEEP;
            sweep_addr_d = '0;
        end else if (state_q == S_SWEEP) begin
            if (sweep_addr_q == LAST_ADDR) begin
                state_d = S_IDLE;
            end else begin
                sweep_addr_d = sweep_addr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request entry, stage A -> B, and read result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid         <= 1'b0;
            a_mode          <= 1'b0;
            a_addr          <= '0;
            a_data          <= '0;
            r_valid         <= 1'b0;
            r_addr          <= '0;
            b_valid         <= 1'b0;
            b_addr          <= '0;
            b_data          <= '0;
            read_data_valid <= 1'b0;
            read_data       <= '0;
        end else begin
            // Requests presented while busy are dropped, not queued.
            a_valid <= write & ~busy;
            a_mode  <= write_mode;
            a_addr  <= write_address;
            a_data  <= write_data;
            r_valid <= read & ~busy;
            r_addr  <= read_address;

            b_valid <= a_live;
            b_addr  <= a_addr;
            b_data  <= a_new;

            read_data_valid <= r_live;
            if (r_live) begin
                read_data <= r_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address range checks
    // ------------------------------------------------------------------
    a_write_addr_in_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        write |-> (int'(write_address) < DEPTH)
    );

    a_read_addr_in_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        read |-> (int'(read_address) < DEPTH)
    );

endmodule

// File: doc/svnet_acc_ram.md
# svnet_acc_ram

Single-clock, single-write/single-read RAM with a per-write store-or-accumulate mode, full read-after-write forwarding and a hardware clear sweep. It sustains one write plus one read per cycle with no write-to-write or read-to-read gap. It sits beside the convolution datapath as the partial-sum store: products are accumulated into it across kernel passes and read out when a pass finishes.

## Interface
- DEPTH, 1, number of words; address width is $clog2(DEPTH), minimum 1.
- WIDTH, 1, word width; data is two's-complement signed.
- SATURATE, 0, 1 = accumulate clamps to the signed range; 0 = accumulate wraps modulo 2^WIDTH.

- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  start a zero-fill sweep of the whole array.
- busy  out  1  sweep in progress.
- write  in  1  write request.
- write_mode  in  1  0 = store, 1 = accumulate.
- write_address  in  $clog2(DEPTH)  write address, must be < DEPTH.
- write_data  in  WIDTH  store value or addend.
- read  in  1  read request.
- read_address  in  $clog2(DEPTH)  read address, must be < DEPTH.
- read_data_valid  out  1  read_data holds a result this cycle.
- read_data  out  WIDTH  read result.

## Operation
- All inputs are registered on entry and all outputs are registered.
- The array is not reset. Contents after reset are undefined until a clear sweep runs or each word is written.
- Write pipeline:
  - Stage A (cycle after request): fetch the old word, then compute new = data for a store or old + data for an accumulate.
  - Stage B (next cycle): commit new to the array at the end of that cycle.
- Forwarding: when stage B holds a valid write to the same address as a stage-A write or a registered read, the stage-B value replaces the array value.
- Read semantics: a read presented in cycle M returns the word including every write presented in cycles ≤ M-1. It excludes a write presented in cycle M (read-before-write).
- Accumulate arithmetic is a signed WIDTH+1-bit sum:
  - SATURATE=0: keep the low WIDTH bits.
  - SATURATE=1: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- Clear sweep, for clear presented in cycle N:
  - The write presented in N-1 (still in the pipeline) and any write presented in N are discarded.
  - A read presented in N-1 completes normally.
  - A read presented in N is dropped.
  - Address k is written 0 at the end of cycle N+1+k, for k = 0..DEPTH-1.
- While busy is high, write and read requests are ignored, with no queuing and no read_data_valid.
- clear while busy restarts the sweep at address 0.
- Assertions (disabled during reset): write implies write_address < DEPTH; read implies read_address < DEPTH.

## Timing
- Reset values: busy=0, read_data_valid=0, read_data=0, pipeline valids 0.
- Reset mid-sweep aborts the sweep; the array is then partially cleared and undefined.
- Read latency:
  - A read presented in cycle M gives read_data_valid=1 with data in cycle M+2, for one cycle.
  - read_data holds its last value while read_data_valid=0.
- Write commit: a write presented in cycle N is in the array at the end of cycle N+2. It is visible to reads presented in cycle N+1 or later through forwarding.
- Throughput: one write and one read per cycle, any address mix, including back-to-back accumulates to one address.
- busy is high in cycles N+1..N+DEPTH for clear presented in cycle N. The first request accepted after the sweep is one presented in cycle N+DEPTH+1.

## Test plan
- Store then read: store 5 to address 3 in cycle 0, read 3 in cycle 1 -> read_data_valid=1 with 5 in cycle 3. Read 3 in cycle 0 -> old value (not 5) in cycle 2.
- Back-to-back accumulate, WIDTH=8: store 10 to address 2, then accumulate +1, +2, -4 in consecutive cycles. A read in the next cycle -> 9. Check that no update is lost, which exercises forwarding.
- Saturation, WIDTH=8:
  - SATURATE=1: 120 + 20 -> 127; -120 + -20 -> -128.
  - SATURATE=0: 120 + 20 -> -116.
- Clear, DEPTH=16: fill with nonzero values, pulse clear in cycle N with a write in N.
  - busy is high exactly in N+1..N+16.
  - Requests during busy produce nothing.
  - After the sweep, reads of all 16 addresses return 0, including the address written in N.
- Clear restart: pulse clear again mid-sweep -> busy stays high until 16 cycles after the second pulse.
- Reset: assert rst_n low mid-sweep and mid-read -> busy, read_data_valid and read_data go to 0 immediately (asynchronous), and no read_data_valid appears after release.
